// File: rtl/bcd_counter_7seg.sv
// N-digit BCD up/down counter with registered common-anode 7-segment decode.
// Counts on rising edges of debounced up/down/clear levels; wraps or saturates at the ends.
// Optional feature: define AUTO_REPEAT_EN to add a per-direction hold-to-repeat FSM.
module bcd_counter_7seg #(
    parameter int unsigned NUM_DIGITS    = 2,
    parameter int unsigned WRAP_MODE     = 1,
    parameter int unsigned BLANK_LEADING = 0,
    parameter int unsigned REPEAT_DELAY  = 12_500_000,
    parameter int unsigned REPEAT_PERIOD = 2_500_000
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_Up,
    input  logic                    i_Down,
    input  logic                    i_Clear,
    output logic [4*NUM_DIGITS-1:0] o_Count_BCD,
    output logic [7*NUM_DIGITS-1:0] o_Segments,
    output logic                    o_Wrap
);

    localparam int unsigned CW = 4 * NUM_DIGITS;
    localparam int unsigned SW = 7 * NUM_DIGITS;

    logic          up_q, down_q, clear_q;
    logic          up_ev, down_ev, clear_ev;
    logic          step_up, step_down;
    logic [CW-1:0] count_q, count_d, count_inc, count_dec;
    logic          inc_carry, dec_borrow;
    logic          wrap_q, wrap_d;
    logic [SW-1:0] seg_q, seg_d;

    // Edge-detect history; reset to 1 so a level held through reset is not an event
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            up_q    <= 1'b1;
            down_q  <= 1'b1;
            clear_q <= 1'b1;
        end else begin
            up_q    <= i_Up;
            down_q  <= i_Down;
            clear_q <= i_Clear;
        end
    end

    assign up_ev    = i_Up & ~up_q;
    assign down_ev  = i_Down & ~down_q;
    assign clear_ev = i_Clear & ~clear_q;

`ifdef AUTO_REPEAT_EN
    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

    localparam int unsigned MaxWait = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW      = $clog2(MaxWait + 1);
    localparam logic [TW-1:0] DelayLast  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PeriodLast = TW'(REPEAT_PERIOD - 1);

    // Index 0 = up, index 1 = down
    rep_state_e    state_q [2];
    rep_state_e    state_d [2];
    logic [TW-1:0] timer_q [2];
    logic [TW-1:0] timer_d [2];
    logic [1:0]    held, ev, rep_step;

    assign held = {i_Down, i_Up};
    assign ev   = {down_ev, up_ev};

    // Repeat FSM state and hold timers
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            for (int d = 0; d < 2; d++) begin
                state_q[d] <= StIdle;
                timer_q[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                state_q[d] <= state_d[d];
                timer_q[d] <= timer_d[d];
            end
        end
    end

    // Repeat FSM next state; a step fires when a delay or period expires while held
    always_comb begin
        rep_step = '0;
        for (int d = 0; d < 2; d++) begin
            state_d[d] = state_q[d];
            timer_d[d] = timer_q[d];
            if (!held[d] || clear_ev || (i_Up && i_Down)) begin
                state_d[d] = StIdle;
                timer_d[d] = '0;
            end else begin
                case (state_q[d])
                    StIdle: begin
                        if (ev[d]) begin
                            state_d[d] = StDelay;
                            timer_d[d] = '0;
                        end
                    end
                    StDelay: begin
                        if (timer_q[d] == DelayLast) begin
                            state_d[d]  = StRepeat;
                            timer_d[d]  = '0;
                            rep_step[d] = 1'b1;
                        end else begin
                            timer_d[d] = timer_q[d] + TW'(1);
                        end
                    end
                    StRepeat: begin
                        if (timer_q[d] == PeriodLast) begin
                            timer_d[d]  = '0;
                            rep_step[d] = 1'b1;
                        end else begin
                            timer_d[d] = timer_q[d] + TW'(1);
                        end
                    end
                    default: begin
                        state_d[d] = StIdle;
                        timer_d[d] = '0;
                    end
                endcase
            end
        end
    end

    assign step_up   = up_ev | rep_step[0];
    assign step_down = down_ev | rep_step[1];
`else
    logic unused_cfg;
    assign unused_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign step_up    = up_ev;
    assign step_down  = down_ev;
`endif

    // Ripple BCD increment/decrement; carry/borrow out means the count was all-9s/zero
    always_comb begin
        count_inc  = count_q;
        count_dec  = count_q;
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (inc_carry) begin
                if (count_q[4*k+:4] == 4'd9) begin
                    count_inc[4*k+:4] = 4'd0;
                end else begin
                    count_inc[4*k+:4] = count_q[4*k+:4] + 4'd1;
                    inc_carry         = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (count_q[4*k+:4] == 4'd0) begin
                    count_dec[4*k+:4] = 4'd9;
                end else begin
                    count_dec[4*k+:4] = count_q[4*k+:4] - 4'd1;
                    dec_borrow        = 1'b0;
                end
            end
        end
    end

    // Event priority: clear, then up+down cancel, then up, then down
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear_ev) begin
            count_d = '0;
        end else if (step_up && step_down) begin
            count_d = count_q;
        end else if (step_up) begin
            if (!inc_carry || WRAP_MODE != 0) begin
                count_d = count_inc;
                wrap_d  = inc_carry;
            end
        end else if (step_down) begin
            if (!dec_borrow || WRAP_MODE != 0) begin
                count_d = count_dec;
                wrap_d  = dec_borrow;
            end
        end
    end

    // Count and wrap pulse registers
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // Returns active-low segments in port order {G,F,E,D,C,B,A}
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] abcdefg;
        logic [6:0] gfedcba;
        case (digit)
            4'd0:    abcdefg = 7'h7E;
            4'd1:    abcdefg = 7'h30;
            4'd2:    abcdefg = 7'h6D;
            4'd3:    abcdefg = 7'h79;
            4'd4:    abcdefg = 7'h33;
            4'd5:    abcdefg = 7'h5B;
            4'd6:    abcdefg = 7'h5F;
            4'd7:    abcdefg = 7'h70;
            4'd8:    abcdefg = 7'h7F;
            4'd9:    abcdefg = 7'h7B;
            default: abcdefg = 7'h00;
        endcase
        for (int i = 0; i < 7; i++) begin
            gfedcba[i] = abcdefg[6-i];
        end
        return ~gfedcba;
    endfunction

    // Segment decode with optional leading-zero blanking, scanned from the top digit down
    always_comb begin
        logic higher_zero;
        seg_d       = '1;
        higher_zero = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            if (BLANK_LEADING != 0 && k > 0 && higher_zero && count_q[4*k+:4] == 4'd0) begin
                seg_d[7*k+:7] = 7'h7F;
            end else begin
                seg_d[7*k+:7] = seg_decode(count_q[4*k+:4]);
            end
            higher_zero = higher_zero & (count_q[4*k+:4] == 4'd0);
        end
    end

    // Registered segment outputs, blank in reset
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            seg_q <= '1;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign o_Count_BCD = count_q;
    assign o_Segments  = seg_q;
    assign o_Wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_counter_7seg.sv
// Directed bench for bcd_counter_7seg: a wrapping instance and a saturating,
// leading-blank instance share the same stimulus. Define AUTO_REPEAT_EN to add the hold test.
module tb_bcd_counter_7seg;

    logic        clk = 1'b0;
    logic        rst;
    logic        up, down, clear;
    logic [7:0]  cnt_m, cnt_s;
    logic [13:0] seg_m, seg_s;
    logic        wrap_m, wrap_s;
    int          n_total = 0;
    int          n_bad   = 0;
    int          wraps;

    always #5 clk = ~clk;

    bcd_counter_7seg #(
        .NUM_DIGITS   (2),
        .WRAP_MODE    (1),
        .BLANK_LEADING(0),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(4)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Up       (up),
        .i_Down     (down),
        .i_Clear    (clear),
        .o_Count_BCD(cnt_m),
        .o_Segments (seg_m),
        .o_Wrap     (wrap_m)
    );

    bcd_counter_7seg #(
        .NUM_DIGITS   (2),
        .WRAP_MODE    (0),
        .BLANK_LEADING(1),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(4)
    ) dut_sat (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Up       (up),
        .i_Down     (down),
        .i_Clear    (clear),
        .o_Count_BCD(cnt_s),
        .o_Segments (seg_s),
        .o_Wrap     (wrap_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One-cycle pulse on the inputs; returns at the negedge after the sampling posedge
    task automatic drive(input logic u, input logic d, input logic c);
        @(negedge clk);
        up    = u;
        down  = d;
        clear = c;
        @(negedge clk);
        up    = 1'b0;
        down  = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        up    = 1'b0;
        down  = 1'b0;
        clear = 1'b0;
        rst   = 1'b0;
        #1;
        rst = 1'b1;
        up  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cnt_m", cnt_m, 8'h00);
        check("rst_cnt_s", cnt_s, 8'h00);
        check("rst_seg_m", seg_m, 14'h3FFF);
        check("rst_seg_s", seg_s, 14'h3FFF);
        check("rst_wrap_m", wrap_m, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("held_at_release_m", cnt_m, 8'h00);
        check("held_at_release_s", cnt_s, 8'h00);
        up = 1'b0;

        drive(1'b1, 1'b0, 1'b0);
        check("first_up_m", cnt_m, 8'h01);
        check("first_up_s", cnt_s, 8'h01);
        @(negedge clk);
        check("seg_blank_01_s", seg_s, 14'h3FF9);

        wraps = 0;
        repeat (98) begin
            drive(1'b1, 1'b0, 1'b0);
            if (wrap_m || wrap_s) wraps++;
        end
        check("up99_cnt_m", cnt_m, 8'h99);
        check("up99_cnt_s", cnt_s, 8'h99);
        check("up99_no_wrap", wraps, 0);
        @(negedge clk);
        check("seg_99_m", seg_m, 14'h0810);
        check("seg_99_s", seg_s, 14'h0810);

        drive(1'b1, 1'b0, 1'b0);
        check("up_wrap_cnt_m", cnt_m, 8'h00);
        check("up_wrap_pulse_m", wrap_m, 1'b1);
        check("up_sat_cnt_s", cnt_s, 8'h99);
        check("up_sat_wrap_s", wrap_s, 1'b0);
        @(negedge clk);
        check("wrap_one_cycle_m", wrap_m, 1'b0);

        drive(1'b0, 1'b0, 1'b1);
        check("clear_cnt_s", cnt_s, 8'h00);
        check("clear_no_wrap_s", wrap_s, 1'b0);
        @(negedge clk);
        check("seg_blank_00_s", seg_s, 14'h3FC0);

        drive(1'b0, 1'b1, 1'b0);
        check("down_wrap_cnt_m", cnt_m, 8'h99);
        check("down_wrap_pulse_m", wrap_m, 1'b1);
        check("down_sat_cnt_s", cnt_s, 8'h00);
        check("down_sat_wrap_s", wrap_s, 1'b0);
        @(negedge clk);
        check("seg_down_99_m", seg_m, 14'h0810);

        drive(1'b0, 1'b0, 1'b1);
        repeat (42) drive(1'b1, 1'b0, 1'b0);
        check("cnt_42_m", cnt_m, 8'h42);
        drive(1'b1, 1'b1, 1'b0);
        check("up_down_cnt_m", cnt_m, 8'h42);
        check("up_down_cnt_s", cnt_s, 8'h42);
        check("up_down_wrap_m", wrap_m, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        check("clear_up_cnt_m", cnt_m, 8'h00);
        check("clear_up_cnt_s", cnt_s, 8'h00);
        check("clear_up_wrap_m", wrap_m, 1'b0);

        repeat (9) drive(1'b1, 1'b0, 1'b0);
        check("cnt_09_m", cnt_m, 8'h09);
        drive(1'b1, 1'b0, 1'b0);
        check("carry_cnt_m", cnt_m, 8'h10);
        check("carry_cnt_s", cnt_s, 8'h10);
        check("seg_lag_m", seg_m, 14'h2010);
        @(negedge clk);
        check("seg_10_m", seg_m, 14'h3CC0);
        check("seg_10_s", seg_s, 14'h3CC0);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_cnt_m", cnt_m, 8'h00);
        check("async_rst_seg_m", seg_m, 14'h3FFF);
        check("async_rst_cnt_s", cnt_s, 8'h00);
        @(negedge clk);
        rst = 1'b0;

`ifdef AUTO_REPEAT_EN
        @(negedge clk);
        up = 1'b1;
        repeat (10) @(negedge clk);
        check("rep_before_delay_m", cnt_m, 8'h01);
        @(negedge clk);
        check("rep_first_step_m", cnt_m, 8'h02);
        repeat (19) @(negedge clk);
        up = 1'b0;
        check("rep_hold30_m", cnt_m, 8'h06);
        check("rep_hold30_s", cnt_s, 8'h06);
        repeat (10) @(negedge clk);
        check("rep_released_m", cnt_m, 8'h06);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
